// File: rtl/dx_hazard_ctrl.sv
// Decode-to-execute hazard and flow-control unit: 3-entry destination scoreboard,
// RAW stall / redirect flush steering, saturating statistics and a stall watchdog.
module dx_hazard_ctrl #(
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fd_valid,
  input  logic [2:0]  fd_rs,
  input  logic        fd_rs_used,
  input  logic [2:0]  fd_rt,
  input  logic        fd_rt_used,
  input  logic        fd_wr_en,
  input  logic [2:0]  fd_dest,
  input  logic        x_redirect,
  input  logic        mem_stall,
  output logic        pc_hold,
  output logic        fd_hold,
  output logic        dx_bubble,
  output logic        fd_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        hazard_err
);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [2:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SbInvalid = '{valid: 1'b0, wr_en: 1'b0, dest: 3'd0};
  localparam bit        CheckMw   = (RF_BYPASS == 0);
  localparam logic [16:0] MaxStallW = 17'(MAX_STALL);

  sb_entry_t sb_dx_q, sb_dx_d;
  sb_entry_t sb_xm_q, sb_xm_d;
  sb_entry_t sb_mw_q, sb_mw_d;

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] run_len_q, run_len_d;
  logic        hazard_err_q, hazard_err_d;

  logic        raw;
  logic        issue;
  logic        stall_evt;
  logic        flush_evt;
  logic [16:0] run_inc;

  function automatic logic entry_hit(input sb_entry_t e, input logic [2:0] r);
    return e.valid & e.wr_en & (e.dest == r);
  endfunction

  // With a write-before-read register file the MW writer is already visible to decode.
  function automatic logic sb_match(input sb_entry_t dx, input sb_entry_t xm,
                                    input sb_entry_t mw, input logic [2:0] r);
    return entry_hit(dx, r) | entry_hit(xm, r) | (CheckMw & entry_hit(mw, r));
  endfunction

  always_comb begin
    raw = fd_valid &
          ((fd_rs_used & sb_match(sb_dx_q, sb_xm_q, sb_mw_q, fd_rs)) |
           (fd_rt_used & sb_match(sb_dx_q, sb_xm_q, sb_mw_q, fd_rt)));
    issue     = fd_valid & ~mem_stall & ~x_redirect & ~raw;
    stall_evt = raw & ~mem_stall & ~x_redirect;
    flush_evt = x_redirect & ~mem_stall;
  end

  // Memory stall freezes everything; a redirect squashes FD and beats a pending RAW.
  always_comb begin
    pc_hold   = 1'b0;
    fd_hold   = 1'b0;
    dx_bubble = 1'b0;
    fd_flush  = 1'b0;
    if (mem_stall) begin
      pc_hold = 1'b1;
      fd_hold = 1'b1;
    end else if (x_redirect) begin
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
    end else if (raw) begin
      pc_hold   = 1'b1;
      fd_hold   = 1'b1;
      dx_bubble = 1'b1;
    end
  end

  always_comb begin
    sb_dx_d = sb_dx_q;
    sb_xm_d = sb_xm_q;
    sb_mw_d = sb_mw_q;
    if (!mem_stall) begin
      sb_mw_d = sb_xm_q;
      sb_xm_d = sb_dx_q;
      sb_dx_d = issue ? '{valid: 1'b1, wr_en: fd_wr_en, dest: fd_dest} : SbInvalid;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_comb begin
    run_inc      = {1'b0, run_len_q} + 17'd1;
    run_len_d    = run_len_q;
    hazard_err_d = hazard_err_q;
    if (mem_stall) begin
      run_len_d = run_len_q;
    end else if (stall_evt) begin
      run_len_d = run_inc[16] ? 16'hFFFF : run_inc[15:0];
      if (run_inc > MaxStallW) begin
        hazard_err_d = 1'b1;
      end
    end else begin
      run_len_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_dx_q      <= SbInvalid;
      sb_xm_q      <= SbInvalid;
      sb_mw_q      <= SbInvalid;
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      run_len_q    <= 16'd0;
      hazard_err_q <= 1'b0;
    end else begin
      sb_dx_q      <= sb_dx_d;
      sb_xm_q      <= sb_xm_d;
      sb_mw_q      <= sb_mw_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      run_len_q    <= run_len_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_dx_hazard_ctrl.sv
// Scoreboard bench for dx_hazard_ctrl: two instances (bypassing RF / MAX_STALL=3 and
// non-bypassing RF / MAX_STALL=1) share stimulus and are checked against a pending-write model.
module tb_dx_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fd_valid;
  logic [2:0] fd_rs;
  logic       fd_rs_used;
  logic [2:0] fd_rt;
  logic       fd_rt_used;
  logic       fd_wr_en;
  logic [2:0] fd_dest;
  logic       x_redirect;
  logic       mem_stall;

  logic        pc_hold    [2];
  logic        fd_hold    [2];
  logic        dx_bubble  [2];
  logic        fd_flush   [2];
  logic [15:0] stall_cnt  [2];
  logic [15:0] flush_cnt  [2];
  logic        hazard_err [2];

  always #5 clk = ~clk;

  dx_hazard_ctrl #(.RF_BYPASS(1), .MAX_STALL(3)) u_byp (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rs_used(fd_rs_used),
    .fd_rt(fd_rt), .fd_rt_used(fd_rt_used), .fd_wr_en(fd_wr_en), .fd_dest(fd_dest),
    .x_redirect(x_redirect), .mem_stall(mem_stall), .pc_hold(pc_hold[0]),
    .fd_hold(fd_hold[0]), .dx_bubble(dx_bubble[0]), .fd_flush(fd_flush[0]),
    .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]), .hazard_err(hazard_err[0])
  );

  dx_hazard_ctrl #(.RF_BYPASS(0), .MAX_STALL(1)) u_nobyp (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rs_used(fd_rs_used),
    .fd_rt(fd_rt), .fd_rt_used(fd_rt_used), .fd_wr_en(fd_wr_en), .fd_dest(fd_dest),
    .x_redirect(x_redirect), .mem_stall(mem_stall), .pc_hold(pc_hold[1]),
    .fd_hold(fd_hold[1]), .dx_bubble(dx_bubble[1]), .fd_flush(fd_flush[1]),
    .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]), .hazard_err(hazard_err[1])
  );

  typedef struct {
    bit ph;
    bit fh;
    bit bub;
    bit fl;
    int sc;
    int fc;
    bit er;
  } exp_t;

  exp_t expq [2][$];

  // Model: per instance, the destinations still in flight, youngest first (-1 = no write).
  int pend   [2][3];
  int scnt   [2];
  int fcnt   [2];
  int runlen [2];
  bit err    [2];
  int byp    [2] = '{1, 0};
  int maxst  [2] = '{3, 1};

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;
  bit last_hold = 1'b0;

  function automatic void chk(input string name, input int k, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s[dut%0d] t=%0t got=%0d want=%0d", name, k, $time, act, req);
    end
  endfunction

  function automatic bit pending(input int k, input int r);
    int lim = (byp[k] != 0) ? 2 : 3;
    for (int i = 0; i < lim; i++) if (pend[k][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) pend[k][i] = -1;
      scnt[k] = 0; fcnt[k] = 0; runlen[k] = 0; err[k] = 1'b0;
    end
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [2:0] rs, input bit rsu,
                     input logic [2:0] rt, input bit rtu, input bit we, input logic [2:0] d,
                     input bit xr, input bit ms);
    exp_t e;
    bit   raw;
    rst = r; fd_valid = v; fd_rs = rs; fd_rs_used = rsu; fd_rt = rt; fd_rt_used = rtu;
    fd_wr_en = we; fd_dest = d; x_redirect = xr; mem_stall = ms;
    for (int k = 0; k < 2; k++) begin
      raw = v && ((rsu && pending(k, int'(rs))) || (rtu && pending(k, int'(rt))));
      e = '{ph: 0, fh: 0, bub: 0, fl: 0, sc: scnt[k], fc: fcnt[k], er: err[k]};
      if (ms) begin
        e.ph = 1; e.fh = 1;
      end else if (xr) begin
        e.fl = 1; e.bub = 1;
      end else if (raw) begin
        e.ph = 1; e.fh = 1; e.bub = 1;
      end
      expq[k].push_back(e);
      if (k == 0) last_hold = e.fh;
      // Advance the model across the coming clock edge.
      if (!r) begin
        for (int i = 0; i < 3; i++) pend[k][i] = -1;
        scnt[k] = 0; fcnt[k] = 0; runlen[k] = 0; err[k] = 1'b0;
      end else if (!ms) begin
        pend[k][2] = pend[k][1];
        pend[k][1] = pend[k][0];
        pend[k][0] = (v && !xr && !raw && we) ? int'(d) : -1;
        if (xr) begin
          if (fcnt[k] < 65535) fcnt[k]++;
          runlen[k] = 0;
        end else if (raw) begin
          if (scnt[k] < 65535) scnt[k]++;
          runlen[k]++;
          if (runlen[k] > maxst[k]) err[k] = 1'b1;
        end else begin
          runlen[k] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          if (expq[k].size() == 0) begin
            chk("no_expectation", k, 0, 1);
          end else begin
            e = expq[k].pop_front();
            chk("pc_hold",    k, int'(pc_hold[k]),    int'(e.ph));
            chk("fd_hold",    k, int'(fd_hold[k]),    int'(e.fh));
            chk("dx_bubble",  k, int'(dx_bubble[k]),  int'(e.bub));
            chk("fd_flush",   k, int'(fd_flush[k]),   int'(e.fl));
            chk("stall_cnt",  k, int'(stall_cnt[k]),  e.sc);
            chk("flush_cnt",  k, int'(flush_cnt[k]),  e.fc);
            chk("hazard_err", k, int'(hazard_err[k]), int'(e.er));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0] rs, rt, d;
    bit         v, rsu, rtu, we;
    rst = 0; fd_valid = 0; fd_rs = 0; fd_rs_used = 0; fd_rt = 0; fd_rt_used = 0;
    fd_wr_en = 0; fd_dest = 0; x_redirect = 0; mem_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;

    // Independent instruction, nothing pending.
    cyc(1, 1, 3'd3, 1, 3'd0, 0, 1, 3'd5, 0, 0);
    idle(3);
    // Write r2 then read r2: 2-cycle stall with bypass, 3 without.
    cyc(1, 1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 0);
    repeat (4) cyc(1, 1, 3'd2, 1, 3'd0, 0, 0, 3'd0, 0, 0);
    idle(3);
    // RAW pending together with a redirect.
    cyc(1, 1, 3'd0, 0, 3'd0, 0, 1, 3'd4, 0, 0);
    cyc(1, 1, 3'd4, 1, 3'd0, 0, 0, 3'd0, 1, 0);
    idle(3);
    // Memory stall in the middle of a RAW stall, dependency via rt and r0.
    cyc(1, 1, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0);
    cyc(1, 1, 3'd1, 0, 3'd0, 1, 0, 3'd0, 0, 0);
    repeat (4) cyc(1, 1, 3'd1, 0, 3'd0, 1, 0, 3'd0, 0, 1);
    repeat (3) cyc(1, 1, 3'd1, 0, 3'd0, 1, 0, 3'd0, 0, 0);
    // Reset clears the sticky error and statistics.
    cyc(0, 1, 3'd1, 0, 3'd0, 1, 0, 3'd0, 0, 0);
    idle(2);

    v = 0; rs = 0; rt = 0; d = 0; rsu = 0; rtu = 0; we = 0;
    for (int n = 0; n < 3000; n++) begin
      // Mostly re-present the held instruction so stalls run their full length.
      if (!(last_hold && ($urandom_range(0, 4) != 0))) begin
        v   = ($urandom_range(0, 9) != 0);
        rs  = 3'($urandom_range(0, 3));
        rt  = 3'($urandom_range(0, 3));
        rsu = $urandom_range(0, 1) != 0;
        rtu = $urandom_range(0, 2) == 0;
        we  = $urandom_range(0, 3) != 0;
        d   = 3'($urandom_range(0, 3));
      end
      cyc(($urandom_range(0, 99) != 0), v, rs, rsu, rt, rtu, we, d,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end

    armed = 1'b0;
    for (int k = 0; k < 2; k++) chk("queue_drained", k, expq[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
